// File: rtl/syn_fetch_buffer_pkg.sv
// Shared core constants for the fetch path.
//   CORE_IM_ADDR_BIT : instruction-memory word-address width used core-wide
//   INS_BIT          : instruction width
//   INS_NOP          : NOP encoding, also the reset value of the decode head
package syn_fetch_buffer_pkg;

    localparam int CORE_IM_ADDR_BIT = 10;
    localparam int INS_BIT          = 32;
    localparam logic [INS_BIT-1:0] INS_NOP = 32'h0000_0000;

endpackage

// File: rtl/syn_fetch_buffer_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode
// valid/ready handshake.
//   master : the fetch buffer (drives im_rd_en/im_addr and the decode head)
//   slave  : memory + decode side (drives im_data and ins_ready)
interface syn_fetch_buffer_if
    import syn_fetch_buffer_pkg::*;
#(
    parameter int IM_ADDR_BIT = CORE_IM_ADDR_BIT
);

    logic                   im_rd_en;
    logic [IM_ADDR_BIT-1:0] im_addr;
    logic [INS_BIT-1:0]     im_data;
    logic                   ins_valid;
    logic [INS_BIT-1:0]     ins;
    logic [IM_ADDR_BIT-1:0] ins_pc;
    logic                   ins_ready;

    modport master (
        output im_rd_en, im_addr, ins_valid, ins, ins_pc,
        input  im_data, ins_ready
    );

    modport slave (
        input  im_rd_en, im_addr, ins_valid, ins, ins_pc,
        output im_data, ins_ready
    );

endinterface

// File: rtl/syn_fetch_buffer_fifo.sv
// syn_fifo: small circular queue with a registered head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry (ignored when full or clearing)
//   pop        : retire the head (ignored when empty or clearing)
//   clear      : drop all entries; read pointer jumps to write pointer
//   dout       : head entry, registered; holds its last value when empty
//   count      : occupancy 0..DEPTH
//   empty/full : occupancy flags
module syn_fifo #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_BIT = $clog2(DEPTH);
    localparam int CNT_BIT = PTR_BIT + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_BIT-1:0] rd_ptr;
    logic [PTR_BIT-1:0] wr_ptr;
    logic [PTR_BIT-1:0] rd_next;
    logic [CNT_BIT-1:0] cnt_next;
    logic               push_ok;
    logic               pop_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_BIT'(DEPTH));

    always_comb begin
        pop_ok   = pop && !empty && !clear;
        push_ok  = push && !full && !clear;
        rd_next  = clear ? wr_ptr : rd_ptr + PTR_BIT'(pop_ok);
        cnt_next = clear ? '0 : count + CNT_BIT'(push_ok) - CNT_BIT'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // The head register is loaded with whatever will sit at the next read
    // pointer; when that slot is the one being written this edge, the
    // incoming word is forwarded so a one-deep queue streams at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= RESET_VAL;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PTR_BIT'(push_ok);
            count  <= cnt_next;
            if (cnt_next != '0) begin
                dout <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/syn_fetch_buffer.sv
// Instruction fetch buffer. Issues one instruction-memory read per cycle at
// the current PC, advances the PC, queues returned words with their address
// and hands them to decode over valid/ready. A flush drops queued and
// in-flight words while the PC loads the redirect target.
//   clk, rst_n : clock, asynchronous active-low reset
//   pc         : current PC register value (word address)
//   pc_en      : PC register load enable
//   halt       : stop issuing fetches
//   flush      : redirect; PC loads the target this cycle
//   bus        : memory read port + decode handshake (master side)
module syn_fetch_buffer
    import syn_fetch_buffer_pkg::*;
#(
    parameter int IM_ADDR_BIT = CORE_IM_ADDR_BIT,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IM_ADDR_BIT-1:0] pc,
    output logic                   pc_en,
    input  logic                   halt,
    input  logic                   flush,
    syn_fetch_buffer_if.master     bus
);

    localparam int CNT_BIT   = $clog2(DEPTH) + 1;
    localparam int ENTRY_BIT = INS_BIT + IM_ADDR_BIT;

    logic                   inflight;
    logic                   kill;
    logic [IM_ADDR_BIT-1:0] inflight_pc;
    logic                   issue;
    logic                   capture;
    logic                   pop;
    logic [CNT_BIT-1:0]     fifo_count;
    logic [CNT_BIT-1:0]     credit_used;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [ENTRY_BIT-1:0]   head;

    // Credit counts the word already in flight but not a same-cycle pop,
    // which keeps the issue path free of the decode ready input.
    assign credit_used = fifo_count + CNT_BIT'(inflight);
    assign issue       = !flush && !halt && !fifo_full &&
                         (credit_used < CNT_BIT'(DEPTH));
    assign capture     = inflight && !kill && !flush;
    assign pop         = bus.ins_valid && bus.ins_ready;

    // Flush outranks halt so the redirect target always loads.
    assign pc_en        = rst_n && (issue || flush);
    assign bus.im_rd_en = rst_n && issue;
    assign bus.im_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                kill        <= 1'b0;
            end else if (flush && inflight) begin
                kill <= 1'b1;
            end
        end
    end

    syn_fifo #(
        .WIDTH     (ENTRY_BIT),
        .DEPTH     (DEPTH),
        .RESET_VAL ({INS_NOP, {IM_ADDR_BIT{1'b0}}})
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .din   ({bus.im_data, inflight_pc}),
        .pop   (pop),
        .clear (flush),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.ins_valid = !fifo_empty;
    assign bus.ins       = head[ENTRY_BIT-1 -: INS_BIT];
    assign bus.ins_pc    = head[IM_ADDR_BIT-1:0];

endmodule

// File: tb/tb_syn_fetch_buffer.sv
module tb_syn_fetch_buffer;
    import syn_fetch_buffer_pkg::*;

    localparam int AW    = CORE_IM_ADDR_BIT;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc;
    logic          pc_en;
    logic          halt = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] target = '0;

    int checks = 0;
    int errors = 0;

    syn_fetch_buffer_if #(.IM_ADDR_BIT(AW)) bus ();

    syn_fetch_buffer #(.IM_ADDR_BIT(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc    (pc),
        .pc_en (pc_en),
        .halt  (halt),
        .flush (flush),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // PC register and synchronous instruction memory around the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (pc_en) pc <= flush ? target : pc + 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.im_data <= '0;
        else if (bus.im_rd_en) bus.im_data <= 32'h1000_0000 + 32'(bus.im_addr);
    end

    // A capture must never land in a full queue.
    always @(negedge clk) begin
        if (rst_n && dut.capture && dut.u_fifo.full) begin
            errors++;
            $display("FAIL capture_into_full at %0t", $time);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input logic ready);
        rst_n = 1'b0; halt = 1'b0; flush = 1'b0; bus.ins_ready = ready;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.ins_ready = 1'b1;
        @(negedge clk);
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %0b exp 0", pc_en); end
        checks++; if (bus.im_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", bus.im_rd_en); end
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.ins_valid); end
        checks++; if (bus.ins !== 32'h0) begin errors++; $display("FAIL reset_ins got %0h exp 0", bus.ins); end
        checks++; if (bus.ins_pc !== '0) begin errors++; $display("FAIL reset_ins_pc got %0h exp 0", bus.ins_pc); end
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        @(negedge clk);
        checks++; if (bus.im_rd_en !== 1'b1 || bus.im_addr !== '0) begin errors++; $display("FAIL stream_first_issue got rd=%0b addr=%0d exp rd=1 addr=0", bus.im_rd_en, bus.im_addr); end
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c0 got %0b exp 0", bus.ins_valid); end
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b0 || pc !== AW'(1)) begin errors++; $display("FAIL stream_c1 got valid=%0b pc=%0d exp valid=0 pc=1", bus.ins_valid, pc); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ins_valid !== 1'b1 || bus.ins_pc !== AW'(k) || bus.ins !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL stream_word%0d got valid=%0b pc=%0d ins=%0h exp valid=1 pc=%0d ins=%0h",
                         k, bus.ins_valid, bus.ins_pc, bus.ins, k, 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        int issues = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.im_rd_en === 1'b1) issues++;
        end
        checks++; if (issues != 4) begin errors++; $display("FAIL bp_issue_count got %0d exp 4", issues); end
        checks++; if (pc !== AW'(4) || pc_en !== 1'b0) begin errors++; $display("FAIL bp_pc_hold got pc=%0d en=%0b exp pc=4 en=0", pc, pc_en); end
        checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", dut.u_fifo.count); end
        @(posedge clk); #1;
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ins_valid !== 1'b1 || bus.ins_pc !== AW'(k)) begin
                errors++; $display("FAIL bp_pop%0d got valid=%0b pc=%0d exp valid=1 pc=%0d", k, bus.ins_valid, bus.ins_pc, k);
            end
            if (k == 0) begin
                checks++; if (bus.im_rd_en !== 1'b0) begin errors++; $display("FAIL bp_no_issue_on_pop got %0b exp 0", bus.im_rd_en); end
            end
            if (k == 1) begin
                checks++; if (bus.im_rd_en !== 1'b1 || bus.im_addr !== AW'(4)) begin errors++; $display("FAIL bp_resume got rd=%0b addr=%0d exp rd=1 addr=4", bus.im_rd_en, bus.im_addr); end
            end
        end
    endtask

    task automatic test_flush_redirect();
        bit seen7 = 1'b0;
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ins_valid === 1'b1 && bus.ins_pc === AW'(7)) seen7 = 1'b1;
        end
        checks++; if (bus.im_rd_en !== 1'b1 || bus.im_addr !== AW'(7)) begin errors++; $display("FAIL fl_issue7 got rd=%0b addr=%0d exp rd=1 addr=7", bus.im_rd_en, bus.im_addr); end
        @(posedge clk); #1;
        target = AW'(40); flush = 1'b1;
        @(negedge clk);
        checks++; if (pc_en !== 1'b1 || bus.im_rd_en !== 1'b0) begin errors++; $display("FAIL fl_flush_cycle got en=%0b rd=%0b exp en=1 rd=0", pc_en, bus.im_rd_en); end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (bus.ins_valid === 1'b1 && bus.ins_pc === AW'(7)) seen7 = 1'b1;
            if (j == 1) begin
                checks++; if (pc !== AW'(40) || bus.im_rd_en !== 1'b1 || bus.ins_valid !== 1'b0) begin errors++; $display("FAIL fl_f1 got pc=%0d rd=%0b valid=%0b exp pc=40 rd=1 valid=0", pc, bus.im_rd_en, bus.ins_valid); end
            end else if (j == 2) begin
                checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL fl_f2_valid got %0b exp 0", bus.ins_valid); end
            end else begin
                checks++;
                if (bus.ins_valid !== 1'b1 || bus.ins_pc !== AW'(37 + j) || bus.ins !== 32'h1000_0000 + 32'(37 + j)) begin
                    errors++; $display("FAIL fl_target_f%0d got valid=%0b pc=%0d ins=%0h exp valid=1 pc=%0d", j, bus.ins_valid, bus.ins_pc, bus.ins, 37 + j);
                end
            end
        end
        checks++; if (seen7 !== 1'b0) begin errors++; $display("FAIL fl_stale7 got seen=%0b exp 0", seen7); end
    endtask

    task automatic test_flush_full();
        apply_reset(1'b0);
        repeat (10) @(negedge clk);
        checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL ff_full got %0d exp 4", dut.u_fifo.count); end
        @(posedge clk); #1;
        target = AW'(100); flush = 1'b1; bus.ins_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b1 || pc_en !== 1'b1) begin errors++; $display("FAIL ff_flush_cycle got valid=%0b en=%0b exp valid=1 en=1", bus.ins_valid, pc_en); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b0 || dut.u_fifo.count !== 3'd0 || pc !== AW'(100)) begin errors++; $display("FAIL ff_f1 got valid=%0b count=%0d pc=%0d exp valid=0 count=0 pc=100", bus.ins_valid, dut.u_fifo.count, pc); end
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL ff_f2_valid got %0b exp 0", bus.ins_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== AW'(100 + k)) begin errors++; $display("FAIL ff_word%0d got valid=%0b pc=%0d exp valid=1 pc=%0d", k, bus.ins_valid, bus.ins_pc, 100 + k); end
        end
    endtask

    task automatic test_halt();
        int pops[$];
        int halt_pops = 0;
        apply_reset(1'b1);
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            halt = (c >= 6 && c <= 10);
            @(negedge clk);
            if (halt) begin
                checks++; if (bus.im_rd_en !== 1'b0) begin errors++; $display("FAIL halt_rd_en_c%0d got %0b exp 0", c, bus.im_rd_en); end
            end
            if (bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1) begin
                pops.push_back(int'(bus.ins_pc));
                if (c >= 7 && c <= 12) halt_pops++;
            end
        end
        halt = 1'b0;
        checks++; if (halt_pops != 1) begin errors++; $display("FAIL halt_inflight_delivered got %0d exp 1", halt_pops); end
        checks++; if (pops.size() != 14) begin errors++; $display("FAIL halt_pop_count got %0d exp 14", pops.size()); end
        for (int i = 0; i < pops.size() && i < 14; i++) begin
            checks++; if (pops[i] != i) begin errors++; $display("FAIL halt_order%0d got %0d exp %0d", i, pops[i], i); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        repeat (5) @(negedge clk);
        checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL ar_count got %0d exp 3", dut.u_fifo.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== '0 ||
            pc_en !== 1'b0 || bus.im_rd_en !== 1'b0 || pc !== '0) begin
            errors++;
            $display("FAIL ar_outputs got valid=%0b ins=%0h pc_out=%0d en=%0b rd=%0b pc=%0d exp all 0",
                     bus.ins_valid, bus.ins, bus.ins_pc, pc_en, bus.im_rd_en, pc);
        end
        bus.ins_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.im_rd_en !== 1'b1 || bus.im_addr !== '0) begin errors++; $display("FAIL ar_restart got rd=%0b addr=%0d exp rd=1 addr=0", bus.im_rd_en, bus.im_addr); end
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL ar_valid_c1 got %0b exp 0", bus.ins_valid); end
        @(negedge clk);
        checks++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== '0 || bus.ins !== 32'h1000_0000) begin errors++; $display("FAIL ar_first_word got valid=%0b pc=%0d ins=%0h exp valid=1 pc=0 ins=10000000", bus.ins_valid, bus.ins_pc, bus.ins); end
    endtask

    initial begin
        bus.ins_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_redirect();
        test_flush_full();
        test_halt();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
